// File: rtl/univ_shift_reg_n.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_n
//
// Parametrised universal shift register with single-step and counted
// multi-step operation.
//
// A single step applies the selected mode once:
//   000 hold
//   001 logical shift right
//   010 logical shift left
//   011 rotate right
//   100 rotate left
//   101 arithmetic shift right
//   110 parallel load
//   111 hold (reserved)
//
// A counted operation repeats a shift or rotate mode cnt times, with
// busy/done status reported to the controller.
//
// Handshake: a start pulse is accepted only in IDLE. busy is high from
// the accepting edge until the edge that performs the last step. done
// is high for exactly one cycle after that edge. Requests made while
// busy or done is high are dropped rather than queued, so a controller
// must wait for done before issuing its next start.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              single-step enable (IDLE only)
//   mode[2:0]       operation select
//   din_r / din_l   serial inputs for right / left shifts
//   pin[WIDTH-1:0]  parallel load data
//   start, cnt      counted-operation request and step count
//   out             register contents
//   sout_r          last bit shifted or rotated out of out[0]
//   sout_l          last bit shifted or rotated out of out[WIDTH-1]
//   busy, done      counted-operation status
//   dbg_state_o     FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Parameter constraints:
//   WIDTH >= 2
//   2**CNTW - 1 >= WIDTH, so that a full rotate can be requested
// -----------------------------------------------------------------------------
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             din_r,
    input  logic             din_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNTW-1:0]  cnt,
    output logic [WIDTH-1:0] out,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             sout_r_q;
    logic             sout_r_d;
    logic             sout_l_q;
    logic             sout_l_d;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       mode_q;
    logic [CNTW-1:0]  rem_q;
    logic [2:0]       step_mode;
    logic             start_counted;

    // While running, the latched mode drives the step; otherwise the live mode does.
    assign step_mode = (state_q == ST_RUN) ? mode_q : mode;

    // Only shift/rotate modes with a nonzero count start a real run.
    // Every other start goes directly to DONE.
    assign start_counted = (mode >= M_SHR) && (mode <= M_ASR) && (cnt != '0);

    // One step of step_mode applied to the current register.
    // Serial outputs change only on steps in their own direction.
    always_comb begin
        data_d   = data_q;
        sout_r_d = sout_r_q;
        sout_l_d = sout_l_q;
        case (step_mode)
            M_SHR: begin
                data_d   = {din_r, data_q[WIDTH-1:1]};
                sout_r_d = data_q[0];
            end
            M_SHL: begin
                data_d   = {data_q[WIDTH-2:0], din_l};
                sout_l_d = data_q[WIDTH-1];
            end
            M_ROR: begin
                data_d   = {data_q[0], data_q[WIDTH-1:1]};
                sout_r_d = data_q[0];
            end
            M_ROL: begin
                data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                sout_l_d = data_q[WIDTH-1];
            end
            M_ASR: begin
                data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                sout_r_d = data_q[0];
            end
            M_LOAD: begin
                data_d = pin;
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            sout_r_q <= 1'b0;
            sout_l_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= '0;
            rem_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_counted) begin
                            // Accepting edge: latch the request, no step yet.
                            mode_q  <= mode;
                            rem_q   <= cnt;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else if (en) begin
                        data_q   <= data_d;
                        sout_r_q <= sout_r_d;
                        sout_l_q <= sout_l_d;
                    end
                end
                ST_RUN: begin
                    data_q   <= data_d;
                    sout_r_q <= sout_r_d;
                    sout_l_q <= sout_l_d;
                    rem_q    <= rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out         = data_q;
    assign sout_r      = sout_r_q;
    assign sout_l      = sout_l_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
